led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
- Controller sequencing a one-hot LED pattern from debounced push-buttons, replacing per-rate derived clocks.
- Runs on a single system clock; rate, direction, mode, pause and blanking are selected by button events.
- Stepping uses clock enables only.
- Sits between the board buttons and the LED pins in the LED top level.

Parameters:
- WIDTH, 4: number of pattern LEDs (>=2).
- PRESCALE, 50000: clk cycles per base tick (>=1).
- DEB_CYCLES, 20000: consecutive stable clk cycles needed to accept a button level change (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- buttons  in  8  raw buttons, active-low (0 = pressed).
- leds  out  WIDTH  pattern output, active-high.
- rate  out  3  current rate index, 0..5.
- state  out  2  current ctrl_state_t (see package).

Behaviour:
- Reset is async assert, sync release. Reset values:
  - leds = 1 (bit0)
  - rate = 0, dir = left, mode = rotate
  - state = RUN
  - prescaler and step counter = 0
  - all debounced levels = released
- Debounce, per bit:
  - The debounced level changes only after the raw level has differed from it for DEB_CYCLES consecutive clocks.
  - Any raw bounce back clears the count.
  - A press event is a 1-cycle pulse in the cycle the debounced level becomes pressed.
  - The control action is registered on the next edge.
- Button map:
  - b0: run/pause toggle.
  - b1: slower, rate+1, saturates at 5.
  - b2: faster, rate-1, saturates at 0.
  - b3: toggle dir.
  - b4: toggle mode (rotate/bounce).
  - b5: blank, level-sensitive while debounced pressed.
  - b6, b7: unused.
- Simultaneous events among b0..b4 in one cycle: only the lowest index is acted on; the others are dropped.
- Base tick: 1-cycle pulse every PRESCALE clocks. It is free-running from reset and unaffected by state.
- Step period = RATE_DIV[rate] base ticks, with RATE_DIV = {1,2,4,8,16,32}.
- The step counter advances on ticks only in RUN.
- A rate change clears the step counter, so the next step is a full new period after the change.
- Pattern step, on the tick that completes the period:
  - rotate, left: {p[W-2:0], p[W-1]}; rotate, right: {p[0], p[W-1:1]}. Wrap-around is inherent.
  - bounce: shift in dir. If p is already at the end in dir (bit W-1 for left, bit0 for right), dir flips and p shifts one position the other way in the same step, so the end LED is never held for two steps.
- A dir toggle in bounce mode takes effect from the next step.
- The pattern register is always exactly one-hot.
- FSM (ctrl_state_t):
  - RUN: b0 -> PAUSE; b5 pressed -> BLANK (saves RUN).
  - PAUSE: step counter frozen; b0 -> RUN; b5 -> BLANK (saves PAUSE).
  - BLANK: leds = 0; pattern and step counter frozen.
    - b5 release -> saved state, same pattern.
    - b0 is ignored in BLANK; b1..b4 still apply.
- Blank has priority over a b0 event in the same cycle.
- leds is registered: it shows the pattern in RUN/PAUSE and 0 in BLANK, updating the cycle after the state or pattern changes.
- Reset mid-operation returns to the reset values immediately, including any in-progress debounce count.

Decomposition:
- Package led_pkg:
  - ctrl_state_t enum {RUN, PAUSE, BLANK}
  - mode_t, dir_t
  - RATE_DIV[6] table
  - button index constants BTN_RUN .. BTN_BLANK
- Sub-module led_deb: single-bit debouncer with DEB_CYCLES parameter, outputs level and press pulse; instantiated 8 times.
- Prescaler, step counter, pattern logic and FSM live in led_seq_ctrl.

Test Plan (WIDTH=4, PRESCALE=4, DEB_CYCLES=3):
1. Reset release, no buttons -> leds 0001, then 0010, 0100, 1000, 0001 on successive steps every 4 clocks; state = RUN, rate = 0.
2. b1 pressed twice (each held >=4 clocks) -> rate = 2, steps 16 clocks apart; b2 pressed three times -> rate = 0 (saturates), no underflow.
3. b4 press (bounce), left -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; b3 during rotate -> sequence reverses: 0100 -> 0010.
4. b0 press -> state = PAUSE, leds frozen at 0100; hold b5 -> leds 0000, state = BLANK; release -> leds 0100, state = PAUSE; b0 -> RUN, stepping resumes.
5. b1 low for only 2 clocks -> no rate change. b1 and b2 pressed in the same cycle -> only rate+1. b0 and b5 together from RUN -> BLANK, and after release state = RUN.
6. Assert reset mid-step at rate 3 with b5 held -> leds 0001, rate = 0, state = RUN on the reset assert. After release, b5 still held -> BLANK entered only after 3 stable cycles.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED sequencer: control states, stepping modes,
// rate divider table and button assignments.
package led_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        BLANK = 2'd2
    } ctrl_state_t;

    typedef enum logic {
        MODE_ROTATE = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int unsigned NUM_RATES = 6;
    localparam int unsigned RATE_DIV [NUM_RATES] = '{1, 2, 4, 8, 16, 32};
    localparam logic [2:0]  RATE_MAX = 3'd5;

    localparam int unsigned BTN_RUN   = 0;
    localparam int unsigned BTN_SLOW  = 1;
    localparam int unsigned BTN_FAST  = 2;
    localparam int unsigned BTN_DIR   = 3;
    localparam int unsigned BTN_MODE  = 4;
    localparam int unsigned BTN_BLANK = 5;

    // Terminal step-counter value for a rate index; out-of-range indices map to the slowest rate.
    function automatic logic [4:0] step_last(input logic [2:0] r);
        logic [4:0] v;
        v = 5'd31;
        for (int unsigned i = 0; i < NUM_RATES; i++) begin
            if (r == 3'(i)) v = 5'(RATE_DIV[i] - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Board-side bundle for the LED sequencer: raw active-low buttons in, pattern and status out.
interface led_seq_ctrl_if #(parameter int unsigned WIDTH = 4);
    logic [7:0]       buttons;
    logic [WIDTH-1:0] leds;
    logic [2:0]       rate;
    logic [1:0]       state;

    modport master (output buttons, input leds, rate, state);
    modport slave  (input buttons, output leds, rate, state);
endinterface

// File: rtl/led_deb.sv
// Single-bit debouncer: level follows the raw input after DEB_CYCLES consecutive differing
// clocks; press pulses for one cycle as the level becomes pressed.
module led_deb #(
    parameter int unsigned DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int unsigned   CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= raw;
                press <= raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// One-hot LED pattern sequencer driven by debounced buttons; all stepping is done with
// clock enables derived from a free-running base-tick prescaler.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned DEB_CYCLES = 20000
) (
    input  logic           clk,
    input  logic           reset,
    led_seq_ctrl_if.slave  io
);
    localparam int unsigned   PW       = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [7:0] deb_level;
    logic [7:0] deb_press;
    logic       unused_btn;

    for (genvar g = 0; g < 8; g++) begin : g_deb
        led_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (~io.buttons[g]),
            .level (deb_level[g]),
            .press (deb_press[g])
        );
    end

    assign unused_btn = ^{deb_level[7:6], deb_level[4:0], deb_press[7:5]};

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [4:0]       step_cnt;
    logic [2:0]       rate_q;
    logic             rate_chg;
    logic             step_en;
    logic [WIDTH-1:0] pattern_q, pattern_d, rot_l, rot_r, leds_q, leds_d;
    dir_t             dir_q, dir_d;
    mode_t            mode_q;
    ctrl_state_t      state_q, state_d, saved_q, saved_d;
    logic             blank_lvl;
    logic             act_run, act_slow, act_fast, act_dir, act_mode;

    assign tick      = (pre_cnt == PRE_LAST);
    assign blank_lvl = deb_level[BTN_BLANK];

    // Simultaneous events: only the lowest-indexed button is acted on.
    always_comb begin
        act_run  = 1'b0;
        act_slow = 1'b0;
        act_fast = 1'b0;
        act_dir  = 1'b0;
        act_mode = 1'b0;
        if (deb_press[BTN_RUN])       act_run  = 1'b1;
        else if (deb_press[BTN_SLOW]) act_slow = 1'b1;
        else if (deb_press[BTN_FAST]) act_fast = 1'b1;
        else if (deb_press[BTN_DIR])  act_dir  = 1'b1;
        else if (deb_press[BTN_MODE]) act_mode = 1'b1;
    end

    assign rate_chg = (act_slow && rate_q != RATE_MAX) || (act_fast && rate_q != 3'd0);
    assign step_en  = (state_q == RUN) && tick && (step_cnt == step_last(rate_q)) && !rate_chg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
            rate_q   <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (act_slow && rate_q != RATE_MAX)  rate_q <= rate_q + 3'd1;
            else if (act_fast && rate_q != 3'd0) rate_q <= rate_q - 3'd1;
            if (rate_chg)
                step_cnt <= '0;
            else if (state_q == RUN && tick)
                step_cnt <= (step_cnt == step_last(rate_q)) ? 5'd0 : step_cnt + 5'd1;
        end
    end

    assign rot_l = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
    assign rot_r = {pattern_q[0], pattern_q[WIDTH-1:1]};

    // A bounce at the end flips direction and moves the opposite way in the same step;
    // a button toggle is applied on top so it governs the following step.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        if (step_en) begin
            if (mode_q == MODE_BOUNCE && dir_q == DIR_LEFT && pattern_q[WIDTH-1]) begin
                dir_d     = DIR_RIGHT;
                pattern_d = rot_r;
            end else if (mode_q == MODE_BOUNCE && dir_q == DIR_RIGHT && pattern_q[0]) begin
                dir_d     = DIR_LEFT;
                pattern_d = rot_l;
            end else begin
                pattern_d = (dir_q == DIR_LEFT) ? rot_l : rot_r;
            end
        end
        if (act_dir) dir_d = (dir_d == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= WIDTH'(1);
            dir_q     <= DIR_LEFT;
            mode_q    <= MODE_ROTATE;
        end else begin
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            if (act_mode) mode_q <= (mode_q == MODE_ROTATE) ? MODE_BOUNCE : MODE_ROTATE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            saved_q <= RUN;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        case (state_q)
            RUN: begin
                if (blank_lvl) begin
                    state_d = BLANK;
                    saved_d = RUN;
                end else if (act_run) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (blank_lvl) begin
                    state_d = BLANK;
                    saved_d = PAUSE;
                end else if (act_run) begin
                    state_d = RUN;
                end
            end
            BLANK: begin
                if (!blank_lvl) state_d = saved_q;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        leds_d = (state_q == BLANK) ? '0 : pattern_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) leds_q <= WIDTH'(1);
        else        leds_q <= leds_d;
    end

    assign io.leds  = leds_q;
    assign io.rate  = rate_q;
    assign io.state = state_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: a cycle model pushes expected outputs per clock and the
// sampled DUT outputs are popped against them, plus hand-derived checkpoints.
module tb_led_seq_ctrl;
    localparam int W   = 4;
    localparam int PRE = 4;
    localparam int DEB = 3;

    typedef struct {
        logic [W-1:0] leds;
        logic [2:0]   rate;
        logic [1:0]   state;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    led_seq_ctrl_if #(.WIDTH(W)) io ();

    led_seq_ctrl #(.WIDTH(W), .PRESCALE(PRE), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    // Reference model state (state codes: 0 run, 1 pause, 2 blank; dir 1 = right; mode 1 = bounce)
    int           m_cnt [8];
    bit           m_lvl [8];
    bit           m_prs [8];
    int           m_pre, m_step, m_rate, m_state, m_saved;
    bit           m_dir, m_mode;
    logic [W-1:0] m_pat, m_leds;
    int           divs [6] = '{1, 2, 4, 8, 16, 32};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cnt[i] = 0;
            m_lvl[i] = 0;
            m_prs[i] = 0;
        end
        m_pre = 0; m_step = 0; m_rate = 0; m_state = 0; m_saved = 0;
        m_dir = 0; m_mode = 0; m_pat = 1; m_leds = 1;
    endtask

    task automatic model_clock();
        bit           tick, chg, stepped, nd, nm, raw;
        int           ev, nr, nstep, ns, nsv;
        logic [W-1:0] np, nl;
        tick = (m_pre == PRE - 1);
        ev = -1;
        for (int i = 4; i >= 0; i--) if (m_prs[i]) ev = i;
        nr = m_rate; chg = 0;
        if (ev == 1 && m_rate < 5) begin nr = m_rate + 1; chg = 1; end
        if (ev == 2 && m_rate > 0) begin nr = m_rate - 1; chg = 1; end
        nstep = m_step; stepped = 0;
        if (chg) nstep = 0;
        else if (m_state == 0 && tick) begin
            if (m_step + 1 == divs[m_rate]) begin nstep = 0; stepped = 1; end
            else nstep = m_step + 1;
        end
        np = m_pat; nd = m_dir;
        if (stepped) begin
            if (m_mode && ((!m_dir && m_pat[W-1]) || (m_dir && m_pat[0]))) nd = !m_dir;
            np = nd ? ((m_pat >> 1) | (m_pat << (W - 1))) : ((m_pat << 1) | (m_pat >> (W - 1)));
        end
        if (ev == 3) nd = !nd;
        nm = (ev == 4) ? !m_mode : m_mode;
        ns = m_state; nsv = m_saved;
        if (m_state == 2) begin
            if (!m_lvl[5]) ns = m_saved;
        end else if (m_lvl[5]) begin
            nsv = m_state; ns = 2;
        end else if (ev == 0) begin
            ns = (m_state == 0) ? 1 : 0;
        end
        nl = (m_state == 2) ? '0 : m_pat;
        for (int i = 0; i < 8; i++) begin
            raw = !io.buttons[i];
            m_prs[i] = 0;
            if (raw == m_lvl[i]) m_cnt[i] = 0;
            else if (m_cnt[i] + 1 == DEB) begin
                m_lvl[i] = raw; m_prs[i] = raw; m_cnt[i] = 0;
            end else m_cnt[i]++;
        end
        m_pre  = tick ? 0 : m_pre + 1;
        m_rate = nr; m_step = nstep; m_pat = np; m_dir = nd; m_mode = nm;
        m_state = ns; m_saved = nsv; m_leds = nl;
    endtask

    // One clock: model advances and pushes expectations at the edge, DUT is sampled at negedge.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        if (!reset) model_reset();
        else model_clock();
        e.leds = m_leds; e.rate = 3'(m_rate); e.state = 2'(m_state);
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_val("leds", io.leds, e.leds);
            check_val("rate", io.rate, e.rate);
            check_val("state", io.state, e.state);
        end
    endtask

    task automatic press_btn(input int idx, input int hold, input int gap);
        io.buttons[idx] = 1'b0;
        repeat (hold) cyc();
        io.buttons[idx] = 1'b1;
        repeat (gap) cyc();
    endtask

    task automatic wait_change(input string tag, output logic [W-1:0] v, output int n);
        logic [W-1:0] prev;
        prev = io.leds;
        n = 0;
        while (io.leds == prev && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) check_val(tag, 0, 1);
        v = io.leds;
    endtask

    logic [W-1:0] seen;
    logic [W-1:0] bounce_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    int           ncyc;

    initial begin
        reset = 1'b0;
        io.buttons = '1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Free-running rotate at rate 0
        for (int n = 1; n <= 17; n++) begin
            cyc();
            if (n == 1)  check_val("t1_leds_init", io.leds, 4'b0001);
            if (n == 1)  check_val("t1_state", io.state, 0);
            if (n == 5)  check_val("t1_step1", io.leds, 4'b0010);
            if (n == 9)  check_val("t1_step2", io.leds, 4'b0100);
            if (n == 13) check_val("t1_step3", io.leds, 4'b1000);
            if (n == 17) check_val("t1_wrap", io.leds, 4'b0001);
        end

        // Slower twice, period check, then faster saturating at 0
        press_btn(1, 4, 4);
        press_btn(1, 4, 4);
        check_val("t2_rate2", io.rate, 2);
        wait_change("t2_wait_a", seen, ncyc);
        wait_change("t2_wait_b", seen, ncyc);
        check_val("t2_period", ncyc, 16);
        for (int i = 0; i < 3; i++) press_btn(2, 4, 4);
        check_val("t2_rate_sat0", io.rate, 0);

        // Bounce mode sequence from the right end
        press_btn(4, 4, 2);
        ncyc = 0;
        while (io.leds != 4'b0001 && ncyc < 100) begin cyc(); ncyc++; end
        check_val("t3_reach_0001", io.leds, 4'b0001);
        for (int i = 0; i < 7; i++) begin
            wait_change("t3_wait", seen, ncyc);
            check_val("t3_bounce", seen, bounce_seq[i]);
        end
        press_btn(4, 4, 4);
        press_btn(3, 4, 12);

        // Pause, blank while paused, resume
        press_btn(0, 4, 4);
        check_val("t4_pause", io.state, 1);
        repeat (8) cyc();
        io.buttons[5] = 1'b0;
        repeat (6) cyc();
        check_val("t4_blank_leds", io.leds, 0);
        check_val("t4_blank_state", io.state, 2);
        io.buttons[5] = 1'b1;
        repeat (6) cyc();
        check_val("t4_unblank", io.state, 1);
        press_btn(0, 4, 12);
        check_val("t4_resume", io.state, 0);

        // Short glitch, simultaneous presses, run+blank together
        press_btn(1, 2, 6);
        check_val("t5_glitch_rate", io.rate, 0);
        io.buttons[1] = 1'b0; io.buttons[2] = 1'b0;
        repeat (5) cyc();
        io.buttons[1] = 1'b1; io.buttons[2] = 1'b1;
        repeat (4) cyc();
        check_val("t5_simul_rate", io.rate, 1);
        io.buttons[0] = 1'b0; io.buttons[5] = 1'b0;
        repeat (6) cyc();
        check_val("t5_b0b5_blank", io.state, 2);
        io.buttons[0] = 1'b1; io.buttons[5] = 1'b1;
        repeat (6) cyc();
        check_val("t5_b0b5_run", io.state, 0);

        // Reset mid-step at rate 3 with blank held
        press_btn(1, 4, 4);
        press_btn(1, 4, 9);
        check_val("t6_rate3", io.rate, 3);
        io.buttons[5] = 1'b0;
        repeat (7) cyc();
        reset = 1'b0;
        #1;
        check_val("t6_rst_leds", io.leds, 1);
        check_val("t6_rst_rate", io.rate, 0);
        check_val("t6_rst_state", io.state, 0);
        model_reset();
        repeat (3) cyc();
        reset = 1'b1;
        repeat (3) cyc();
        check_val("t6_deb_hold", io.state, 0);
        cyc();
        check_val("t6_blank_after", io.state, 2);
        io.buttons[5] = 1'b1;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
